// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory acting as the responder of a
// four-phase Req/Ack bus, with a fixed number of wait states per access.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              WE,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Ack,
  output logic [DATA_W-1:0] RData,
  output logic              Err,
  output logic              Busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_we;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_range = (32'(addr_q) < 32'(DEPTH));
  assign idx      = addr_q[IDX_W-1:0];

  assign Ack   = ack_q;
  assign RData = rdata_q;
  assign Err   = err_q;
  assign Busy  = busy_q;

  // Next-state and next-output logic for the request/wait/acknowledge cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    case (state)
      S_IDLE: begin
        if (Req) begin
          addr_d  = Addr;
          we_d    = WE;
          wdata_d = WData;
          cnt_d   = 4'(WAIT_CYCLES);
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = S_ACK;
          if (in_range) begin
            if (we_q) mem_we = 1'b1;
            else      rdata_d = mem[idx];
          end else begin
            err_d = 1'b1;
            if (!we_q) rdata_d = '0;
          end
        end
      end
      S_ACK: begin
        // A Req already low here (dropped early) still gives one Ack cycle.
        if (!Req) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Memory array write port; never cleared, and blocked while Reset is high.
  always_ff @(posedge Clk) begin
    if (!Reset && mem_we) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives two responders (2 and 0 wait states) with the same
// directed transactions and checks them every cycle against a timeline model.
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset, Req, WE;
  logic [7:0]  Addr;
  logic [15:0] WData;
  logic        ack_o   [2];
  logic [15:0] rdata_o [2];
  logic        err_o   [2];
  logic        busy_o  [2];

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  int wc [2] = '{2, 0};

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .Addr(Addr), .WData(WData),
    .Ack(ack_o[0]), .RData(rdata_o[0]), .Err(err_o[0]), .Busy(busy_o[0])
  );

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .Addr(Addr), .WData(WData),
    .Ack(ack_o[1]), .RData(rdata_o[1]), .Err(err_o[1]), .Busy(busy_o[1])
  );

  always #5 Clk = ~Clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: each accepted request completes at edge accept+1+wait, then
  // Ack holds until the first edge that sees Req low.
  int          ecount = 0;
  logic [15:0] mm      [2][256];
  bit          in_txn  [2];
  bit          acked   [2];
  int          done_e  [2];
  logic [7:0]  t_addr  [2];
  bit          t_we    [2];
  logic [15:0] t_wd    [2];
  bit          e_ack   [2];
  bit          e_err   [2];
  bit          e_busy  [2];
  logic [15:0] e_rd    [2];

  // Model update on each active edge, from the inputs held since the negedge.
  always @(posedge Clk) begin
    ecount++;
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        e_ack[k] = 1'b0; e_rd[k] = '0; e_err[k] = 1'b0; e_busy[k] = 1'b0;
        in_txn[k] = 1'b0; acked[k] = 1'b0;
      end else if (!in_txn[k]) begin
        if (Req) begin
          in_txn[k] = 1'b1;
          done_e[k] = ecount + 1 + wc[k];
          t_addr[k] = Addr; t_we[k] = WE; t_wd[k] = WData;
          e_busy[k] = 1'b1; e_err[k] = 1'b0;
        end
      end else if (!acked[k]) begin
        if (ecount == done_e[k]) begin
          acked[k] = 1'b1;
          e_ack[k] = 1'b1;
          if (t_addr[k] < 8'd128) begin
            if (t_we[k]) mm[k][t_addr[k]] = t_wd[k];
            else         e_rd[k] = mm[k][t_addr[k]];
          end else begin
            e_err[k] = 1'b1;
            if (!t_we[k]) e_rd[k] = '0;
          end
        end
      end else if (!Req) begin
        e_ack[k] = 1'b0; e_busy[k] = 1'b0; in_txn[k] = 1'b0; acked[k] = 1'b0;
      end
    end
  end

  // Per-cycle comparison of both responders against the model.
  always @(negedge Clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ack[%0d]", k),   ack_o[k],   e_ack[k]);
        check($sformatf("busy[%0d]", k),  busy_o[k],  e_busy[k]);
        check($sformatf("err[%0d]", k),   err_o[k],   e_err[k]);
        check($sformatf("rdata[%0d]", k), rdata_o[k], e_rd[k]);
      end
    end
  end

  int          last_lat, last_lat1;
  logic [15:0] last_rd;
  logic        last_err;

  task automatic txn(input bit w, input logic [7:0] a, input logic [15:0] d,
                     input bit scramble);
    int lat;
    bit got;
    @(negedge Clk);
    Req = 1'b1; WE = w; Addr = a; WData = d;
    @(posedge Clk); #1;
    check("busy_on_accept", busy_o[0], 1'b1);
    if (scramble) begin
      Addr = a ^ 8'h55; WData = ~d; WE = ~w;
    end
    lat = 0; got = 1'b0; last_lat1 = 0;
    while (!got && lat < 40) begin
      @(posedge Clk); lat++; #1;
      if (ack_o[1] && last_lat1 == 0) last_lat1 = lat;
      if (ack_o[0]) got = 1'b1;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    last_lat = lat; last_rd = rdata_o[0]; last_err = err_o[0];
    @(negedge Clk);
    Req = 1'b0;
    @(posedge Clk); #1;
    check("ack_fall", ack_o[0], 1'b0);
    check("busy_fall", busy_o[0], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs0, highs1;
    Reset = 1'b1; Req = 1'b0; WE = 1'b0; Addr = '0; WData = '0;
    @(posedge Clk); #1;
    cmp_en = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // Reset mid-idle for two cycles
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("rst_ack", ack_o[k], 1'b0);
      check("rst_rdata", rdata_o[k], 16'h0000);
      check("rst_err", err_o[k], 1'b0);
      check("rst_busy", busy_o[k], 1'b0);
    end

    txn(1'b1, 8'd0, 16'h0055, 1'b0);

    // Write then read back, latency of the 2-wait responder
    txn(1'b1, 8'd20, 16'd6, 1'b0);
    check("wr_latency", last_lat, 3);
    txn(1'b0, 8'd20, 16'd0, 1'b0);
    check("rd_latency", last_lat, 3);
    check("rd20", last_rd, 16'd6);
    check("rd20_err", last_err, 1'b0);
    check("w0_latency", last_lat1, 1);

    // Boundary addresses
    txn(1'b1, 8'd127, 16'h8001, 1'b0);
    txn(1'b0, 8'd127, 16'd0, 1'b0);
    check("rd127", last_rd, 16'h8001);
    check("rd127_err", last_err, 1'b0);
    txn(1'b1, 8'd128, 16'h1234, 1'b0);
    check("wr128_err", last_err, 1'b1);
    txn(1'b0, 8'd0, 16'd0, 1'b0);
    check("rd0_no_alias", last_rd, 16'h0055);
    txn(1'b0, 8'd200, 16'd0, 1'b0);
    check("rd200", last_rd, 16'h0000);
    check("rd200_err", last_err, 1'b1);

    // Back-to-back transactions and latching
    txn(1'b1, 8'd21, 16'd4, 1'b0);
    txn(1'b1, 8'd22, 16'd13, 1'b0);
    txn(1'b0, 8'd21, 16'd0, 1'b0);
    check("rd21", last_rd, 16'd4);
    txn(1'b0, 8'd22, 16'd0, 1'b0);
    check("rd22", last_rd, 16'd13);
    txn(1'b1, 8'd25, 16'h0A0A, 1'b1);
    txn(1'b0, 8'd25, 16'd0, 1'b1);
    check("rd25_latched", last_rd, 16'h0A0A);
    txn(1'b0, 8'd112, 16'd0, 1'b0);
    check("rd112_untouched", last_rd, 16'hxxxx);

    // Reset during WAIT aborts a pending write
    txn(1'b1, 8'd23, 16'h0000, 1'b0);
    @(negedge Clk);
    Req = 1'b1; WE = 1'b1; Addr = 8'd23; WData = 16'hBEEF;
    @(negedge Clk);
    Reset = 1'b1; Req = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    highs0 = 0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (ack_o[0]) highs0++;
    end
    check("abort_no_ack", highs0, 0);
    txn(1'b0, 8'd23, 16'd0, 1'b0);
    check("rd23_after_abort", last_rd, 16'h0000);

    // One-cycle Req pulse still commits and yields a single Ack pulse
    @(negedge Clk);
    Req = 1'b1; WE = 1'b1; Addr = 8'd24; WData = 16'd77;
    @(negedge Clk);
    Req = 1'b0;
    highs0 = 0; highs1 = 0;
    repeat (8) begin
      @(posedge Clk); #1;
      if (ack_o[0]) highs0++;
      if (ack_o[1]) highs1++;
    end
    check("pulse_ack0", highs0, 1);
    check("pulse_ack1", highs1, 1);
    check("pulse_idle", busy_o[0], 1'b0);
    txn(1'b0, 8'd24, 16'd0, 1'b0);
    check("rd24", last_rd, 16'd77);
    check("w0_rd_latency", last_lat1, 1);

    repeat (2) @(negedge Clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
